// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern-select encoding, default 640x480@60 timing
// and the colour-bar channel mapping.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_CHECK = 2'd3
  } mode_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int NUM_BARS = 8;

  // Returns {red_on, green_on, blue_on}: bar 0 is white, bar 7 is black.
  function automatic logic [2:0] bar_channels(input logic [2:0] bar);
    return ~bar;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel-side bundle of the pattern generator: enable/mode in, colour,
// syncs and raster position out.
interface vga_pattern_gen_if
  import vga_pkg::*;
#(
  parameter int COLOR_W = 5,
  parameter int HC_W    = $clog2(DEF_H_TOTAL),
  parameter int VC_W    = $clog2(DEF_V_TOTAL)
);
  logic               en;
  logic [1:0]         mode;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic               frame_start;
  logic [HC_W-1:0]    hcount;
  logic [VC_W-1:0]    vcount;

  modport master (
    input  en, mode,
    output red, green, blue, hsync, vsync, de, frame_start, hcount, vcount
  );

  modport slave (
    output en, mode,
    input  red, green, blue, hsync, vsync, de, frame_start, hcount, vcount
  );
endinterface

// File: rtl/vga_timing.sv
// Raster counters with combinational sync/active/boundary decode of the
// current counter state; the caller registers everything it drives out.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int HC_W     = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VC_W     = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  output logic [HC_W-1:0] h_o,
  output logic [VC_W-1:0] v_o,
  output logic            active_o,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic            frame_first_o,
  output logic            line_end_o,
  output logic            frame_end_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_ACT  = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] H_SS   = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] H_SE   = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_ACT  = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] V_SS   = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] V_SE   = VC_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [HC_W-1:0] h_q;
  logic [VC_W-1:0] v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else if (en_i) begin
      if (h_q == H_LAST) begin
        h_q <= '0;
        v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_q <= h_q + 1'b1;
      end
    end
  end

  assign h_o           = h_q;
  assign v_o           = v_q;
  assign active_o      = (h_q < H_ACT) && (v_q < V_ACT);
  assign hsync_o       = ((h_q >= H_SS) && (h_q < H_SE)) ? HS_POL : ~HS_POL;
  assign vsync_o       = ((v_q >= V_SS) && (v_q < V_SE)) ? VS_POL : ~VS_POL;
  assign frame_first_o = (h_q == '0) && (v_q == '0);
  assign line_end_o    = (h_q == H_LAST);
  assign frame_end_o   = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing master and test-pattern source; every output is registered one
// en cycle behind the raster counters, and nothing advances while en is low.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int COLOR_W    = 5,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int CHECK_LOG2 = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_pattern_gen_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / NUM_BARS;
  localparam int BP_W    = $clog2(BAR_W + 1);

  localparam logic [BP_W-1:0] BAR_LAST  = BP_W'(BAR_W - 1);
  localparam logic [2:0]      BAR_FINAL = 3'(NUM_BARS - 1);

  logic [HC_W-1:0] h;
  logic [VC_W-1:0] v;
  logic            active, hs, vs, frame_first, line_end, frame_end;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .HC_W(HC_W), .VC_W(VC_W)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (vif.en),
    .h_o          (h),
    .v_o          (v),
    .active_o     (active),
    .hsync_o      (hs),
    .vsync_o      (vs),
    .frame_first_o(frame_first),
    .line_end_o   (line_end),
    .frame_end_o  (frame_end)
  );

  mode_e              mode_q, mode_d;
  logic [2:0]         bar_q;
  logic [BP_W-1:0]    bar_px_q;
  logic [COLOR_W-1:0] frame_q;
  logic [COLOR_W-1:0] red_q, green_q, blue_q;
  logic [COLOR_W-1:0] red_d, green_d, blue_d;
  logic               hsync_q, vsync_q, de_q, frame_start_q;
  logic [HC_W-1:0]    hcount_q;
  logic [VC_W-1:0]    vcount_q;
  logic [2:0]         bar_on;

  // A new mode is latched at the frame boundary and already drives that pixel.
  always_comb begin
    mode_d  = frame_first ? mode_e'(vif.mode) : mode_q;
    bar_on  = bar_channels(bar_q);
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (active) begin
      case (mode_d)
        MODE_SOLID: begin
          red_d   = '1;
          green_d = '1;
          blue_d  = '1;
        end
        MODE_BARS: begin
          red_d   = {COLOR_W{bar_on[2]}};
          green_d = {COLOR_W{bar_on[1]}};
          blue_d  = {COLOR_W{bar_on[0]}};
        end
        MODE_GRAD: begin
          red_d   = h[COLOR_W-1:0];
          green_d = v[COLOR_W-1:0];
          blue_d  = frame_q;
        end
        default: begin
          red_d   = {COLOR_W{~(h[CHECK_LOG2] ^ v[CHECK_LOG2])}};
          green_d = {COLOR_W{~(h[CHECK_LOG2] ^ v[CHECK_LOG2])}};
          blue_d  = {COLOR_W{~(h[CHECK_LOG2] ^ v[CHECK_LOG2])}};
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q        <= MODE_SOLID;
      bar_q         <= '0;
      bar_px_q      <= '0;
      frame_q       <= '0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
    end else begin
      // Cleared on idle cycles so a stalled pixel clock never stretches the pulse.
      frame_start_q <= vif.en & frame_first;
      if (vif.en) begin
        mode_q   <= mode_d;
        red_q    <= red_d;
        green_q  <= green_d;
        blue_q   <= blue_d;
        hsync_q  <= hs;
        vsync_q  <= vs;
        de_q     <= active;
        hcount_q <= h;
        vcount_q <= v;
        if (frame_end) begin
          frame_q <= frame_q + 1'b1;
        end
        // Remainder pixels past the last full bar stay in the final bar.
        if (line_end) begin
          bar_q    <= '0;
          bar_px_q <= '0;
        end else if (bar_q != BAR_FINAL) begin
          if (bar_px_q == BAR_LAST) begin
            bar_q    <= bar_q + 1'b1;
            bar_px_q <= '0;
          end else begin
            bar_px_q <= bar_px_q + 1'b1;
          end
        end
      end
    end
  end

  assign vif.red         = red_q;
  assign vif.green       = green_q;
  assign vif.blue        = blue_q;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.de          = de_q;
  assign vif.frame_start = frame_start_q;
  assign vif.hcount      = hcount_q;
  assign vif.vcount      = vcount_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench on a reduced raster (84x48 total, 68x40 active) so that
// several whole frames, an en-toggled frame and a mid-frame reset fit in the run.
module tb_vga_pattern_gen;
  localparam int CW  = 5;
  localparam int HA  = 68, HF = 4, HS = 8, HB = 4;
  localparam int VA  = 40, VF = 2, VS = 3, VB = 3;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;
  localparam int FT  = HT * VT;
  localparam int HCW = $clog2(HT);
  localparam int VCW = $clog2(VT);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_pattern_gen_if #(.COLOR_W(CW), .HC_W(HCW), .VC_W(VCW)) vif ();

  vga_pattern_gen #(
    .COLOR_W(CW),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b1), .CHECK_LOG2(5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .vif  (vif)
  );

  typedef struct {
    int t;
    int r;
    int g;
    int b;
    int de;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic add_vec(input int f, input int v, input int h,
                         input int r, input int g, input int b, input int de);
    vec_t e;
    e.t  = f * FT + v * HT + h;
    e.r  = r;
    e.g  = g;
    e.b  = b;
    e.de = de;
    vecs.push_back(e);
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_red"},    32'(vif.red),         0);
    chk({pfx, "_green"},  32'(vif.green),       0);
    chk({pfx, "_blue"},   32'(vif.blue),        0);
    chk({pfx, "_de"},     32'(vif.de),          0);
    chk({pfx, "_fs"},     32'(vif.frame_start), 0);
    chk({pfx, "_hsync"},  32'(vif.hsync),       1);
    chk({pfx, "_vsync"},  32'(vif.vsync),       0);
    chk({pfx, "_hcount"}, 32'(vif.hcount),      0);
    chk({pfx, "_vcount"}, 32'(vif.vcount),      0);
  endtask

  function automatic logic [63:0] snapshot();
    return 64'({vif.red, vif.green, vif.blue, vif.hsync, vif.vsync,
                vif.de, vif.hcount, vif.vcount});
  endfunction

  initial begin
    int h, v, vi;
    int pos_err, de_err, hs_err, vs_err, fs_err, blank_err;
    int hs_cnt, vs_cnt, fs_cnt, de_cnt, same_err;
    logic [63:0] snap;

    // frame 0: colour bars (mode -> 3 mid-frame)
    add_vec(0, 0, 0,  31, 31, 31, 1);
    add_vec(0, 0, 7,  31, 31, 31, 1);
    add_vec(0, 0, 8,  31, 31, 0,  1);
    add_vec(0, 0, 15, 31, 31, 0,  1);
    add_vec(0, 0, 16, 31, 0,  31, 1);
    add_vec(0, 0, 24, 31, 0,  0,  1);
    add_vec(0, 0, 32, 0,  31, 31, 1);
    add_vec(0, 0, 40, 0,  31, 0,  1);
    add_vec(0, 0, 48, 0,  0,  31, 1);
    add_vec(0, 0, 56, 0,  0,  0,  1);
    add_vec(0, 0, 63, 0,  0,  0,  1);
    add_vec(0, 0, 64, 0,  0,  0,  1);
    add_vec(0, 0, 67, 0,  0,  0,  1);
    add_vec(0, 0, 68, 0,  0,  0,  0);
    add_vec(0, 1, 8,  31, 31, 0,  1);
    add_vec(0, 23, 20, 31, 0, 31, 1);
    add_vec(0, 39, 63, 0, 0,  0,  1);
    add_vec(0, 40, 0, 0,  0,  0,  0);
    // frame 1: checkerboard, 32-pixel squares (mode -> 0 mid-frame)
    add_vec(1, 0, 0,   31, 31, 31, 1);
    add_vec(1, 0, 32,  0,  0,  0,  1);
    add_vec(1, 5, 31,  31, 31, 31, 1);
    add_vec(1, 20, 40, 0,  0,  0,  1);
    add_vec(1, 25, 10, 31, 31, 31, 1);
    add_vec(1, 32, 0,  0,  0,  0,  1);
    add_vec(1, 32, 32, 31, 31, 31, 1);
    add_vec(1, 33, 67, 0,  0,  0,  1);
    // frame 2: solid white (mode -> 2 mid-frame, must not tear)
    add_vec(2, 0, 0,   31, 31, 31, 1);
    add_vec(2, 30, 50, 31, 31, 31, 1);
    add_vec(2, 39, 67, 31, 31, 31, 1);
    // frames 3-4: gradient, blue = frame number
    add_vec(3, 0, 0,   0,  0, 3, 1);
    add_vec(3, 0, 37,  5,  0, 3, 1);
    add_vec(3, 35, 10, 10, 3, 3, 1);
    add_vec(3, 39, 67, 3,  7, 3, 1);
    add_vec(3, 40, 0,  0,  0, 0, 0);
    add_vec(4, 0, 0,   0,  0, 4, 1);
    add_vec(4, 2, 31,  31, 2, 4, 1);

    vif.en   = 1'b0;
    vif.mode = 2'd0;
    repeat (3) tick();
    chk_reset("reset");

    vif.en   = 1'b1;
    vif.mode = 2'd1;
    rst_n    = 1'b1;

    vi = 0;
    pos_err = 0; de_err = 0; hs_err = 0; vs_err = 0; fs_err = 0; blank_err = 0;
    hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; de_cnt = 0;
    for (int t = 0; t < 5 * FT; t++) begin
      tick();
      h = t % HT;
      v = (t / HT) % VT;
      if (32'(vif.hcount) !== 32'(h) || 32'(vif.vcount) !== 32'(v)) pos_err++;
      if (vif.de !== ((h < HA) && (v < VA))) de_err++;
      if (vif.hsync !== !((h >= HA + HF) && (h < HA + HF + HS))) hs_err++;
      if (vif.vsync !== ((v >= VA + VF) && (v < VA + VF + VS))) vs_err++;
      if (vif.frame_start !== ((h == 0) && (v == 0))) fs_err++;
      if (!((h < HA) && (v < VA)) && {vif.red, vif.green, vif.blue} !== '0) blank_err++;
      if (vif.hsync === 1'b0) hs_cnt++;
      if (vif.vsync === 1'b1) vs_cnt++;
      if (vif.frame_start === 1'b1) fs_cnt++;
      if (vif.de === 1'b1) de_cnt++;
      if (vi < vecs.size() && vecs[vi].t == t) begin
        chk($sformatf("pix_t%0d_red", t),   32'(vif.red),   vecs[vi].r);
        chk($sformatf("pix_t%0d_green", t), 32'(vif.green), vecs[vi].g);
        chk($sformatf("pix_t%0d_blue", t),  32'(vif.blue),  vecs[vi].b);
        chk($sformatf("pix_t%0d_de", t),    32'(vif.de),    vecs[vi].de);
        vi++;
      end
      if (t == 0 * FT + 23 * HT + 10) vif.mode = 2'd3;
      if (t == 1 * FT + 20 * HT + 0)  vif.mode = 2'd0;
      if (t == 2 * FT + 20 * HT + 5)  vif.mode = 2'd2;
    end
    chk("vectors_hit", vi, vecs.size());
    chk("raster_position", pos_err, 0);
    chk("de_window", de_err, 0);
    chk("hsync_window", hs_err, 0);
    chk("vsync_window", vs_err, 0);
    chk("frame_start_pos", fs_err, 0);
    chk("blank_rgb_zero", blank_err, 0);
    chk("hsync_low_cycles", hs_cnt, 5 * VT * HS);
    chk("vsync_act_cycles", vs_cnt, 5 * HT * VS);
    chk("frame_start_count", fs_cnt, 5);
    chk("de_cycles", de_cnt, 5 * HA * VA);

    // en toggling: each pixel spans two clocks, frame_start only one
    same_err = 0; pos_err = 0; fs_cnt = 0;
    for (int p = 0; p < FT; p++) begin
      vif.en = 1'b1;
      tick();
      if (32'(vif.hcount) !== 32'(p % HT) || 32'(vif.vcount) !== 32'(p / HT)) pos_err++;
      if (vif.frame_start === 1'b1) fs_cnt++;
      if (p == 0) begin
        chk("tog_first_fs", 32'(vif.frame_start), 1);
        chk("tog_first_blue", 32'(vif.blue), 5);
      end
      snap   = snapshot();
      vif.en = 1'b0;
      tick();
      if (snapshot() !== snap) same_err++;
      if (vif.frame_start === 1'b1) fs_cnt++;
    end
    chk("tog_position", pos_err, 0);
    chk("tog_outputs_held", same_err, 0);
    chk("tog_fs_count", fs_cnt, 1);

    vif.en = 1'b1;
    tick();
    chk("frame6_fs", 32'(vif.frame_start), 1);
    chk("frame6_blue", 32'(vif.blue), 6);
    chk("frame6_hcount", 32'(vif.hcount), 0);

    // asynchronous reset in the middle of an active line
    for (int k = 0; k < 20 * HT + 30; k++) tick();
    chk("pre_rst_hcount", 32'(vif.hcount), 30);
    chk("pre_rst_vcount", 32'(vif.vcount), 20);
    chk("pre_rst_green", 32'(vif.green), 20);
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_fs", 32'(vif.frame_start), 1);
    chk("post_rst_de", 32'(vif.de), 1);
    chk("post_rst_hcount", 32'(vif.hcount), 0);
    chk("post_rst_vcount", 32'(vif.vcount), 0);
    chk("post_rst_blue", 32'(vif.blue), 0);
    tick();
    chk("post_rst_h1_red", 32'(vif.red), 1);
    chk("post_rst_h1_fs", 32'(vif.frame_start), 0);
    chk("post_rst_h1_hcount", 32'(vif.hcount), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
